clock_toggle_gen: RTL and testbench

// - Upstream timing source for clock_state: turns a programmable half-period into single-cycle toggle strobes.
// - Provides clock_active, toggle_en and set_clock_low/high, and mirrors the generated clock level internally.
// - Supports free-run or N-cycle bursts, and an orderly stop that always parks the clock at its idle level.

---
 rtl/clock_toggle_gen_pkg.sv | 12 +
 rtl/clock_toggle_gen_half_period_counter.sv | 38 +++
 rtl/clock_toggle_gen.sv | 152 +++++++++++++++
 tb/tb_clock_toggle_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_toggle_gen_pkg.sv
// rtl/clock_toggle_gen_pkg.sv - shared types and default widths for the toggle generator
package clock_toggle_gen_pkg;

  localparam int CTG_HP_W_DEF    = 16;
  localparam int CTG_BURST_W_DEF = 16;

  typedef enum logic {
    CTG_IDLE = 1'b0,
    CTG_RUN  = 1'b1
  } ctg_state_e;

endpackage

// File: rtl/clock_toggle_gen_half_period_counter.sv
// rtl/clock_toggle_gen_half_period_counter.sv - enabled up-counter with terminal-count flag, self-clearing at reload
module half_period_counter #(
  parameter int HP_W = 16
) (
  input  logic            clk,
  input  logic            sync_rst_n,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [HP_W-1:0] reload_i,
  output logic            tc_o
);

  logic [HP_W-1:0] cnt_q;
  logic [HP_W-1:0] cnt_d;

  // Terminal count is purely a compare of the current count; the counter never passes reload_i.
  assign tc_o = (cnt_q == reload_i);

  // Next count: clear has priority, otherwise count up and wrap to zero on terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_toggle_gen.sv
// rtl/clock_toggle_gen.sv - programmable half-period toggle strobe generator with burst and orderly stop
module clock_toggle_gen
  import clock_toggle_gen_pkg::*;
#(
  parameter int HP_W    = CTG_HP_W_DEF,
  parameter int BURST_W = CTG_BURST_W_DEF
) (
  input  logic               clk,
  input  logic               sync_rst_n,
  input  logic               clk_en,
  input  logic [HP_W-1:0]    half_period_i,
  input  logic [BURST_W-1:0] burst_cycles_i,
  input  logic               idle_polarity_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic               clock_active_o,
  output logic               toggle_en_o,
  output logic               set_clock_low_o,
  output logic               set_clock_high_o,
  output logic               level_o,
  output logic               done_o
);

  ctg_state_e         state_q, state_d;
  logic [HP_W-1:0]    hp_q, hp_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] cycles_q, cycles_d;
  logic               pol_q, pol_d;
  logic               level_q, level_d;
  logic               stop_pending_q, stop_pending_d;
  logic               set_low_q, set_low_d;
  logic               set_high_q, set_high_d;
  logic               done_q, done_d;

  logic               run;
  logic               tc;
  logic               toggle;
  logic               completing;
  logic               start_ok;
  logic               burst_end;
  logic               stop_now;
  logic               stop_at_toggle;
  logic               leave;
  logic [BURST_W-1:0] cycles_inc;

  half_period_counter #(
    .HP_W (HP_W)
  ) u_hp_cnt (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .clr_i      (leave),
    .en_i       (clk_en & run),
    .reload_i   (hp_q),
    .tc_o       (tc)
  );

  // Decode this tick's events: toggle, cycle completion, and the three ways out of RUN.
  always_comb begin
    run            = (state_q == CTG_RUN);
    toggle         = run & clk_en & tc;
    completing     = toggle & (level_q != pol_q);
    start_ok       = ~run & start_i & ~stop_i;
    cycles_inc     = cycles_q + 1'b1;
    burst_end      = completing & (burst_q != '0) & (cycles_inc == burst_q);
    // Stopping while parked at idle level without a toggle just truncates the idle phase.
    stop_now       = run & clk_en & stop_i & ~toggle & (level_q == pol_q);
    stop_at_toggle = completing & (stop_i | stop_pending_q);
    leave          = burst_end | stop_at_toggle | stop_now;
  end

  // Next-state and registered pulse outputs; nothing moves while clk_en is low.
  always_comb begin
    state_d        = state_q;
    hp_d           = hp_q;
    burst_d        = burst_q;
    pol_d          = pol_q;
    cycles_d       = cycles_q;
    level_d        = level_q;
    stop_pending_d = stop_pending_q;
    set_low_d      = set_low_q;
    set_high_d     = set_high_q;
    done_d         = done_q;
    if (clk_en) begin
      set_low_d  = 1'b0;
      set_high_d = 1'b0;
      done_d     = 1'b0;
      if (start_ok) begin
        state_d    = CTG_RUN;
        hp_d       = half_period_i;
        burst_d    = burst_cycles_i;
        pol_d      = idle_polarity_i;
        level_d    = idle_polarity_i;
        cycles_d   = '0;
        set_high_d = idle_polarity_i;
        set_low_d  = ~idle_polarity_i;
      end else if (run) begin
        if (toggle) begin
          level_d = ~level_q;
          hp_d    = half_period_i;
          if (completing) begin
            cycles_d = cycles_inc;
          end
        end
        if (stop_i) begin
          stop_pending_d = 1'b1;
        end
        if (leave) begin
          state_d        = CTG_IDLE;
          done_d         = 1'b1;
          cycles_d       = '0;
          stop_pending_d = 1'b0;
          level_d        = pol_q;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state_q        <= CTG_IDLE;
      hp_q           <= '0;
      burst_q        <= '0;
      pol_q          <= 1'b0;
      cycles_q       <= '0;
      level_q        <= 1'b0;
      stop_pending_q <= 1'b0;
      set_low_q      <= 1'b0;
      set_high_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hp_q           <= hp_d;
      burst_q        <= burst_d;
      pol_q          <= pol_d;
      cycles_q       <= cycles_d;
      level_q        <= level_d;
      stop_pending_q <= stop_pending_d;
      set_low_q      <= set_low_d;
      set_high_q     <= set_high_d;
      done_q         <= done_d;
    end
  end

  assign clock_active_o   = run;
  assign toggle_en_o      = toggle;
  assign set_clock_low_o  = set_low_q;
  assign set_clock_high_o = set_high_q;
  assign level_o          = level_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_clock_toggle_gen.sv
// tb/tb_clock_toggle_gen.sv - self-checking bench for clock_toggle_gen
module tb_clock_toggle_gen;

  logic        clk = 1'b0;
  logic        sync_rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic [15:0] half_period_i = '0;
  logic [15:0] burst_cycles_i = '0;
  logic        idle_polarity_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        clock_active_o, toggle_en_o, set_clock_low_o, set_clock_high_o, level_o, done_o;

  always #5 clk = ~clk;

  clock_toggle_gen dut (
    .clk              (clk),
    .sync_rst_n       (sync_rst_n),
    .clk_en           (clk_en),
    .half_period_i    (half_period_i),
    .burst_cycles_i   (burst_cycles_i),
    .idle_polarity_i  (idle_polarity_i),
    .start_i          (start_i),
    .stop_i           (stop_i),
    .clock_active_o   (clock_active_o),
    .toggle_en_o      (toggle_en_o),
    .set_clock_low_o  (set_clock_low_o),
    .set_clock_high_o (set_clock_high_o),
    .level_o          (level_o),
    .done_o           (done_o)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tog_cnt = 0, done_cnt = 0, set_cnt = 0;
  int tog_prev = 0, tog_last = 0;
  int start_cyc = 0;

  // Reference model: a run is a sequence of halves of (hp+1) enabled ticks each.
  bit m_run = 0, m_level = 0, m_pol = 0, m_pend = 0;
  bit m_sl = 0, m_sh = 0, m_done = 0;
  int m_half = 1, m_el = 0, m_cyc = 0, m_burst = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst_n, input bit en, input bit st, input bit sp,
                      input int hp, input int bu, input bit pol);
    bit exp_tog, old, tog, leave;
    @(negedge clk);
    chk("clock_active", clock_active_o, m_run);
    chk("level", level_o, m_level);
    chk("set_low", set_clock_low_o, m_sl);
    chk("set_high", set_clock_high_o, m_sh);
    chk("done", done_o, m_done);
    if (done_o) done_cnt++;
    if (set_clock_low_o || set_clock_high_o) set_cnt++;
    sync_rst_n      = rst_n;
    clk_en          = en;
    start_i         = st;
    stop_i          = sp;
    half_period_i   = hp[15:0];
    burst_cycles_i  = bu[15:0];
    idle_polarity_i = pol;
    #1;
    exp_tog = m_run && en && (m_el + 1 == m_half);
    chk("toggle_en", toggle_en_o, exp_tog);
    if (toggle_en_o) begin
      tog_cnt++;
      tog_prev = tog_last;
      tog_last = cyc;
    end
    if (!rst_n) begin
      m_run = 0; m_level = 0; m_pol = 0; m_pend = 0;
      m_sl = 0; m_sh = 0; m_done = 0; m_el = 0; m_cyc = 0; m_burst = 0; m_half = 1;
    end else if (en) begin
      m_sl = 0; m_sh = 0; m_done = 0;
      if (!m_run) begin
        if (st && !sp) begin
          m_run = 1; m_pol = pol; m_burst = bu; m_half = hp + 1;
          m_el = 0; m_level = pol; m_cyc = 0;
          if (pol) m_sh = 1; else m_sl = 1;
        end
      end else begin
        old = m_level;
        tog = (m_el + 1 == m_half);
        leave = 0;
        if (tog) begin
          m_level = !old;
          m_el = 0;
          m_half = hp + 1;
          if (m_level == m_pol) begin
            m_cyc++;
            if (m_burst != 0 && m_cyc == m_burst) leave = 1;
            if (sp || m_pend) leave = 1;
          end
        end else begin
          m_el++;
          if (sp && old == m_pol) leave = 1;
        end
        if (sp) m_pend = 1;
        if (leave) begin
          m_run = 0; m_done = 1; m_cyc = 0; m_pend = 0; m_el = 0; m_level = m_pol;
        end
      end
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && m_run; i++) step(1, 1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("drain_idle", clock_active_o, 1'b0);
  endtask

  initial begin
    // Reset state.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("rst_active", clock_active_o, 1'b0);
    chk("rst_done", done_o, 1'b0);

    // Burst of two cycles, pol=0, hp=3.
    tog_cnt = 0; done_cnt = 0; set_cnt = 0;
    step(1, 1, 1, 0, 3, 2, 0);
    for (int i = 0; i < 21; i++) step(1, 1, 0, 0, 3, 2, 0);
    chk_int("burst_toggles", tog_cnt, 4);
    chk_int("burst_done", done_cnt, 1);
    chk_int("burst_set", set_cnt, 1);
    chk("burst_level", level_o, 1'b0);

    // hp=0 free run; stop while level=1 gives one more toggle.
    done_cnt = 0;
    step(1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 0);
    if (!m_level) step(1, 1, 0, 0, 0, 0, 0);
    tog_cnt = 0;
    step(1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0);
    chk_int("free_stop_toggles", tog_cnt, 1);
    chk_int("free_stop_done", done_cnt, 1);
    chk("free_stop_level", level_o, 1'b0);

    // pol=1, hp=5, stop mid-half at idle level: immediate, no toggle.
    done_cnt = 0;
    step(1, 1, 1, 0, 5, 0, 1);
    step(1, 1, 0, 0, 5, 0, 1);
    tog_cnt = 0;
    step(1, 1, 0, 1, 5, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 5, 0, 1);
    chk_int("mid_stop_toggles", tog_cnt, 0);
    chk_int("mid_stop_done", done_cnt, 1);
    chk("mid_stop_level", level_o, 1'b1);

    // Half period changed 2->7 mid-half.
    start_cyc = cyc;
    step(1, 1, 1, 0, 2, 0, 0);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0, 7, 0, 0);
    chk_int("hp_first_half", tog_prev - start_cyc, 3);
    chk_int("hp_second_half", tog_last - tog_prev, 8);
    drain();

    // clk_en 1-of-3 with hp=1.
    step(1, 1, 1, 0, 1, 0, 0);
    tog_cnt = 0;
    for (int i = 0; i < 30; i++) step(1, (i % 3) == 0, 0, 0, 1, 0, 0);
    chk_int("clken_toggles", tog_cnt, 5);
    drain();

    // Reset mid-RUN, then start&stop together in IDLE.
    done_cnt = 0; set_cnt = 0;
    step(1, 1, 1, 0, 2, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 2, 0, 1);
    step(0, 1, 0, 0, 2, 0, 1);
    step(1, 1, 1, 1, 2, 0, 1);
    step(1, 1, 0, 0, 2, 0, 1);
    step(1, 1, 0, 0, 2, 0, 1);
    chk_int("rst_run_done", done_cnt, 0);
    chk_int("startstop_set", set_cnt, 1);
    chk("startstop_active", clock_active_o, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 120) != 0, ($urandom % 4) != 0, ($urandom % 6) == 0,
           ($urandom % 15) == 0, $urandom % 4, $urandom % 4, $urandom % 2);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
